seg_scan_decoder: RTL and testbench

Receive-side counterpart of the seven-segment hex decoder. Samples a multiplexed 4-digit seg/an bus and recovers each digit's hex nibble from its segment pattern, using the same active-low encoding. The bus is either looped back from the board's own display driver or taken from an external board on Pmod pins. Provides per-digit values, error flags, and a whole-frame valid pulse for on-board self-test.

---
 rtl/seg_scan_decoder_pkg.sv | 46 ++++
 rtl/seg_scan_decoder_if.sv | 26 ++
 rtl/seg_scan_decoder_pattern_lut.sv | 41 ++++
 rtl/seg_scan_decoder.sv | 124 ++++++++++++
 tb/tb_seg_scan_decoder.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/seg_scan_decoder_pkg.sv
// Shared seven-segment definitions: active-low patterns in a..g order, scan FSM
// states and an_in helpers used by the scan decoder and the display driver.
package seg_pkg;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    localparam logic [0:6] SEG_HEX0  = 7'b0000001;
    localparam logic [0:6] SEG_HEX1  = 7'b1001111;
    localparam logic [0:6] SEG_HEX2  = 7'b0010010;
    localparam logic [0:6] SEG_HEX3  = 7'b0000110;
    localparam logic [0:6] SEG_HEX4  = 7'b1001100;
    localparam logic [0:6] SEG_HEX5  = 7'b0100100;
    localparam logic [0:6] SEG_HEX6  = 7'b0100000;
    localparam logic [0:6] SEG_HEX7  = 7'b0001111;
    localparam logic [0:6] SEG_HEX8  = 7'b0000000;
    localparam logic [0:6] SEG_HEX9  = 7'b0001100;
    localparam logic [0:6] SEG_HEX10 = 7'b0001000;
    localparam logic [0:6] SEG_HEX11 = 7'b1100000;
    localparam logic [0:6] SEG_HEX12 = 7'b0110001;
    localparam logic [0:6] SEG_HEX13 = 7'b1000010;
    localparam logic [0:6] SEG_HEX14 = 7'b0110000;
    localparam logic [0:6] SEG_HEX15 = 7'b0111000;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } scan_state_t;

    // True when exactly one digit enable is driven low.
    function automatic logic an_onehot_low(input logic [3:0] an);
        logic [3:0] en;
        en = ~an;
        return (en != 4'd0) && ((en & (en - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Scanned display bus plus the decoded results seen by the consumer.
// No valid/ready here: capture and frame_valid are single-cycle strobes with no backpressure.
interface seg_scan_decoder_if;
    import seg_pkg::*;

    logic [0:6]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_err;
    logic [15:0] frame;
    logic        frame_valid;
    logic        capture;
    scan_state_t dbg_state;

    modport master (
        output seg_in, an_in,
        input  digits, digit_valid, digit_err, frame, frame_valid, capture, dbg_state
    );

    modport slave (
        input  seg_in, an_in,
        output digits, digit_valid, digit_err, frame, frame_valid, capture, dbg_state
    );

endinterface

// File: rtl/seg_scan_decoder_pattern_lut.sv
// Combinational inverse of the hex display encoder: segment pattern to nibble,
// with separate flags for a recognised digit and an all-off blank.
module seg_pattern_lut
    import seg_pkg::*;
(
    input  logic [0:6] seg,
    output logic       known,
    output logic       blank,
    output logic [3:0] nibble
);

    always_comb begin
        known  = 1'b1;
        blank  = 1'b0;
        nibble = 4'h0;
        case (seg)
            SEG_HEX0:  nibble = 4'h0;
            SEG_HEX1:  nibble = 4'h1;
            SEG_HEX2:  nibble = 4'h2;
            SEG_HEX3:  nibble = 4'h3;
            SEG_HEX4:  nibble = 4'h4;
            SEG_HEX5:  nibble = 4'h5;
            SEG_HEX6:  nibble = 4'h6;
            SEG_HEX7:  nibble = 4'h7;
            SEG_HEX8:  nibble = 4'h8;
            SEG_HEX9:  nibble = 4'h9;
            SEG_HEX10: nibble = 4'hA;
            SEG_HEX11: nibble = 4'hB;
            SEG_HEX12: nibble = 4'hC;
            SEG_HEX13: nibble = 4'hD;
            SEG_HEX14: nibble = 4'hE;
            SEG_HEX15: nibble = 4'hF;
            SEG_BLANK: begin
                known = 1'b0;
                blank = 1'b1;
            end
            default:   known = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the four hex digits from a multiplexed seg/an bus once each digit
// has been stable long enough, and publishes a snapshot when all four are good.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    seg_scan_decoder_if.slave   bus
);

    localparam int             CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_FIRE = CW'(STABLE_CYCLES - 1);

    logic [0:6]    s_seg_q, p_seg_q;
    logic [3:0]    s_an_q, p_an_q;
    logic [CW-1:0] cnt_q, cnt_d;
    scan_state_t   state_q, state_d;
    logic [15:0]   digits_q, digits_d;
    logic [3:0]    valid_q, valid_d;
    logic [3:0]    err_q, err_d;
    logic [15:0]   frame_q, frame_d;
    logic          frame_valid_q, frame_valid_d;
    logic          capture_q, capture_d;

    logic          stable, legal, fire;
    logic          lut_known, lut_blank;
    logic [3:0]    lut_nibble;
    logic [1:0]    k;

    seg_pattern_lut u_lut (
        .seg    (s_seg_q),
        .known  (lut_known),
        .blank  (lut_blank),
        .nibble (lut_nibble)
    );

    always_comb begin
        stable = (s_seg_q == p_seg_q) && (s_an_q == p_an_q);
        legal  = an_onehot_low(s_an_q);
        k      = an_index(s_an_q);
        // cnt_q == STABLE_CYCLES-1 marks the final cycle of the settle window.
        fire   = (state_q == SETTLE) && stable && legal && (cnt_q == CNT_FIRE);

        if (!stable || !legal)    cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        else                       cnt_d = cnt_q;

        state_d = state_q;
        case (state_q)
            WAIT:    if (legal) state_d = SETTLE;
            SETTLE:  if (!stable || !legal) state_d = WAIT;
                     else if (fire)          state_d = HELD;
            HELD:    if (!stable || !legal) state_d = WAIT;
            default: state_d = WAIT;
        endcase

        // A completed frame shows all-valid for one cycle, then starts over.
        digits_d      = digits_q;
        valid_d       = frame_valid_q ? 4'd0 : valid_q;
        err_d         = err_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        capture_d     = fire;

        if (fire) begin
            if (lut_known) begin
                digits_d[{k, 2'b00} +: 4] = lut_nibble;
                valid_d[k]                = 1'b1;
                err_d[k]                  = 1'b0;
                if (valid_d == 4'hF) begin
                    frame_d       = digits_d;
                    frame_valid_d = 1'b1;
                end
            end else if (lut_blank) begin
                valid_d[k] = 1'b0;
            end else begin
                valid_d[k] = 1'b0;
                err_d[k]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_seg_q       <= '0;
            s_an_q        <= '0;
            p_seg_q       <= '0;
            p_an_q        <= '0;
            cnt_q         <= '0;
            state_q       <= WAIT;
            digits_q      <= '0;
            valid_q       <= '0;
            err_q         <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            capture_q     <= 1'b0;
        end else begin
            s_seg_q       <= bus.seg_in;
            s_an_q        <= bus.an_in;
            p_seg_q       <= s_seg_q;
            p_an_q        <= s_an_q;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            digits_q      <= digits_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            capture_q     <= capture_d;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.digit_err   = err_q;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.capture     = capture_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with STABLE_CYCLES = 16.
module tb_seg_scan_decoder;
    import seg_pkg::*;

    localparam int STABLE_CYCLES = 16;
    // Edges counted from the first edge that samples new inputs (that edge is 1).
    localparam int LAT = STABLE_CYCLES + 2;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    int          first_n, caps, fv_count;
    logic [15:0] cap_digits, cap_frame;
    logic [3:0]  cap_dv, cap_err, post_dv;
    logic        cap_fv;

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(.STABLE_CYCLES(STABLE_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [6:0] seg, input logic [3:0] an);
        bus.seg_in = seg;
        bus.an_in  = an;
    endtask

    // Runs a bounded number of edges, sampling 1 ns after each one.
    task automatic watch(input int cycles);
        first_n = 0; caps = 0; fv_count = 0;
        cap_digits = 'x; cap_frame = 'x; cap_dv = 'x; cap_err = 'x; cap_fv = 1'bx;
        post_dv = 'x;
        for (int i = 1; i <= cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.frame_valid) fv_count++;
            if (first_n != 0 && i == first_n + 1) post_dv = bus.digit_valid;
            if (bus.capture) begin
                caps++;
                if (first_n == 0) begin
                    first_n    = i;
                    cap_digits = bus.digits;
                    cap_frame  = bus.frame;
                    cap_dv     = bus.digit_valid;
                    cap_err    = bus.digit_err;
                    cap_fv     = bus.frame_valid;
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(7'b0000001, 4'b1110);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.digits !== 16'h0) begin errors++; $display("FAIL reset_digits: got %h expected 0000", bus.digits); end
        checks++; if (bus.digit_valid !== 4'h0) begin errors++; $display("FAIL reset_valid: got %b expected 0000", bus.digit_valid); end
        checks++; if (bus.digit_err !== 4'h0) begin errors++; $display("FAIL reset_err: got %b expected 0000", bus.digit_err); end
        checks++; if (bus.frame !== 16'h0) begin errors++; $display("FAIL reset_frame: got %h expected 0000", bus.frame); end
        checks++; if (bus.frame_valid !== 1'b0 || bus.capture !== 1'b0) begin errors++; $display("FAIL reset_pulses: got fv=%b cap=%b expected 0 0", bus.frame_valid, bus.capture); end
        checks++; if (bus.dbg_state !== WAIT) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, WAIT); end
        reset = 1'b0;
        watch(20);
        checks++; if (first_n !== LAT) begin errors++; $display("FAIL reset_latency: got %0d expected %0d", first_n, LAT); end
        checks++; if (caps !== 1) begin errors++; $display("FAIL reset_caps: got %0d expected 1", caps); end
        checks++; if (cap_digits[3:0] !== 4'h0 || cap_dv !== 4'b0001) begin errors++; $display("FAIL reset_first: got d=%h v=%b expected 0 0001", cap_digits[3:0], cap_dv); end
    endtask

    task automatic test_frame;
        logic [6:0] segs [4];
        logic [3:0] ans  [4];
        segs = '{7'b0111000, 7'b0010010, 7'b0001000, 7'b1001111};
        ans  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int d = 0; d < 4; d++) begin
            drive(segs[d], ans[d]);
            watch(20);
            checks++; if (first_n !== LAT || caps !== 1) begin errors++; $display("FAIL frame_digit%0d: got at=%0d caps=%0d expected at=%0d caps=1", d, first_n, caps, LAT); end
            if (d < 3) begin
                checks++; if (fv_count !== 0) begin errors++; $display("FAIL frame_early%0d: got %0d pulses expected 0", d, fv_count); end
            end
        end
        checks++; if (cap_frame !== 16'h1A2F) begin errors++; $display("FAIL frame_value: got %h expected 1a2f", cap_frame); end
        checks++; if (cap_fv !== 1'b1 || cap_dv !== 4'b1111) begin errors++; $display("FAIL frame_update: got fv=%b v=%b expected 1 1111", cap_fv, cap_dv); end
        checks++; if (fv_count !== 1) begin errors++; $display("FAIL frame_pulse_len: got %0d expected 1", fv_count); end
        checks++; if (post_dv !== 4'b0000) begin errors++; $display("FAIL frame_valid_clear: got %b expected 0000", post_dv); end
    endtask

    task automatic test_glitch;
        drive(7'b0010010, 4'b1101);
        watch(10);
        checks++; if (caps !== 0) begin errors++; $display("FAIL glitch_early: got %0d expected 0", caps); end
        drive(7'b0000000, 4'b1101);
        watch(1);
        drive(7'b0010010, 4'b1101);
        watch(20);
        checks++; if (first_n !== LAT || caps !== 1) begin errors++; $display("FAIL glitch_capture: got at=%0d caps=%0d expected at=%0d caps=1", first_n, caps, LAT); end
        checks++; if (cap_digits[7:4] !== 4'h2 || cap_dv !== 4'b0010) begin errors++; $display("FAIL glitch_value: got d=%h v=%b expected 2 0010", cap_digits[7:4], cap_dv); end
    endtask

    task automatic test_unknown;
        drive(7'b1010101, 4'b1011);
        watch(20);
        checks++; if (caps !== 1) begin errors++; $display("FAIL unknown_caps: got %0d expected 1", caps); end
        checks++; if (cap_err !== 4'b0100 || cap_digits !== 16'h1A2F) begin errors++; $display("FAIL unknown_flag: got e=%b d=%h expected 0100 1a2f", cap_err, cap_digits); end
        drive(7'b0110000, 4'b1011);
        watch(20);
        checks++; if (cap_err !== 4'b0000 || cap_digits !== 16'h1E2F) begin errors++; $display("FAIL unknown_recover: got e=%b d=%h expected 0000 1e2f", cap_err, cap_digits); end
        checks++; if (cap_dv !== 4'b0110) begin errors++; $display("FAIL unknown_valid: got %b expected 0110", cap_dv); end
    endtask

    task automatic test_blank_illegal;
        drive(7'b0000000, 4'b0111);
        watch(20);
        checks++; if (cap_digits !== 16'h8E2F || cap_dv !== 4'b1110) begin errors++; $display("FAIL blank_pre: got d=%h v=%b expected 8e2f 1110", cap_digits, cap_dv); end
        drive(7'b1111111, 4'b0111);
        watch(20);
        checks++; if (caps !== 1) begin errors++; $display("FAIL blank_caps: got %0d expected 1", caps); end
        checks++; if (cap_dv !== 4'b0110 || cap_err !== 4'b0000 || cap_digits !== 16'h8E2F) begin errors++; $display("FAIL blank_effect: got v=%b e=%b d=%h expected 0110 0000 8e2f", cap_dv, cap_err, cap_digits); end
        drive(7'b0000001, 4'b1100);
        watch(40);
        checks++; if (caps !== 0) begin errors++; $display("FAIL illegal_two_low: got %0d captures expected 0", caps); end
        drive(7'b0000001, 4'b1111);
        watch(40);
        checks++; if (caps !== 0) begin errors++; $display("FAIL illegal_none_low: got %0d captures expected 0", caps); end
        checks++; if (bus.digit_valid !== 4'b0110 || bus.digit_err !== 4'b0000) begin errors++; $display("FAIL illegal_flags: got v=%b e=%b expected 0110 0000", bus.digit_valid, bus.digit_err); end
    endtask

    task automatic test_long_window;
        drive(7'b1001100, 4'b1110);
        watch(60);
        checks++; if (caps !== 1 || first_n !== LAT) begin errors++; $display("FAIL long_window: got caps=%0d at=%0d expected 1 at %0d", caps, first_n, LAT); end
        checks++; if (cap_digits !== 16'h8E24 || cap_dv !== 4'b0111) begin errors++; $display("FAIL long_value: got d=%h v=%b expected 8e24 0111", cap_digits, cap_dv); end
    endtask

    task automatic test_reset_mid_settle;
        drive(7'b0100100, 4'b1101);
        watch(8);
        checks++; if (caps !== 0) begin errors++; $display("FAIL mid_pre: got %0d expected 0", caps); end
        reset = 1'b1;
        watch(1);
        checks++; if (caps !== 0 || bus.digits !== 16'h0 || bus.digit_valid !== 4'h0) begin errors++; $display("FAIL mid_reset: got caps=%0d d=%h v=%b expected 0 0000 0000", caps, bus.digits, bus.digit_valid); end
        reset = 1'b0;
        watch(30);
        checks++; if (first_n !== LAT || caps !== 1) begin errors++; $display("FAIL mid_restart: got at=%0d caps=%0d expected at=%0d caps=1", first_n, caps, LAT); end
        checks++; if (cap_digits !== 16'h0050 || cap_dv !== 4'b0010) begin errors++; $display("FAIL mid_value: got d=%h v=%b expected 0050 0010", cap_digits, cap_dv); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_glitch();
        test_unknown();
        test_blank_illegal();
        test_long_window();
        test_reset_mid_settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
